act_window_stream: RTL and testbench

Multi-channel activation memory with a sequential sliding-window scanner. ENTRY_NUM channels of DIM x DIM words are written one word at a time. On start, an FSM walks every KERNEL_DIM x KERNEL_DIM window origin with a configurable stride, in raster order. For each origin it emits the full window for all channels on a registered valid/ready stream. It sits between the layer-output writeback and the convolution MAC array, and generalises the combinational single-window parallel read to a strided, back-pressured, self-sequencing stream.

---
 rtl/act_window_stream.sv | 177 +++++++++++++++++
 tb/tb_act_window_stream.sv | 226 ++++++++++++++++++++++
 2 files changed

// File: rtl/act_window_stream.sv
// Multi-channel activation memory with a strided, back-pressured sliding-window scanner.
// Optional zero "same" padding is compiled in with ACT_WIN_ZERO_PAD_EN.
module act_window_stream #(
  parameter int    DEBUG      = 0,
  parameter string NAME       = "DEFAULT ACT WIN",
  parameter int    ENTRY_NUM  = 16,
  parameter int    DIM        = 8,
  parameter int    DATA_SIZE  = 64,
  parameter int    KERNEL_DIM = 3,
  parameter int    STRIDE     = 1
) (
  input  logic                                                 clk,
  input  logic                                                 rst_n,
  input  logic                                                 write,
  input  logic [15:0]                                          index_entry,
  input  logic [15:0]                                          index_y,
  input  logic [15:0]                                          index_x,
  input  logic [DATA_SIZE-1:0]                                 in_data,
  input  logic                                                 start,
  output logic                                                 busy,
  output logic                                                 done,
  output logic                                                 out_valid,
  input  logic                                                 out_ready,
  output logic [ENTRY_NUM*KERNEL_DIM*KERNEL_DIM*DATA_SIZE-1:0] out_data,
  output logic [15:0]                                          out_y,
  output logic [15:0]                                          out_x,
  output logic                                                 out_last
);

  localparam int WIN_W     = ENTRY_NUM * KERNEL_DIM * KERNEL_DIM * DATA_SIZE;
  localparam int MEM_DEPTH = ENTRY_NUM * DIM * DIM;
  localparam int AW        = (MEM_DEPTH > 1) ? $clog2(MEM_DEPTH) : 1;
`ifdef ACT_WIN_ZERO_PAD_EN
  localparam int PAD = (KERNEL_DIM - 1) / 2;
`else
  localparam int PAD = 0;
`endif
  localparam int OUT_DIM = (DIM + 2 * PAD - KERNEL_DIM) / STRIDE + 1;
  localparam logic [15:0] LAST_IDX = 16'(OUT_DIM - 1);

  localparam logic [1:0] ST_IDLE = 2'd0;
  localparam logic [1:0] ST_SCAN = 2'd1;
  localparam logic [1:0] ST_DONE = 2'd2;

  logic [DATA_SIZE-1:0] mem_q [MEM_DEPTH];

  logic [1:0]       state_q, state_d;
  logic [15:0]      cy_q, cy_d, cx_q, cx_d;
  logic             loaded_all_q, loaded_all_d;
  logic             busy_q, busy_d, done_q, done_d;
  logic             out_valid_q, out_valid_d, out_last_q, out_last_d;
  logic [WIN_W-1:0] out_data_q, out_data_d;
  logic [15:0]      out_y_q, out_y_d, out_x_q, out_x_d;

  logic             wr_ok;
  logic [AW-1:0]    wr_addr;
  int               org_y, org_x;
  logic             is_final;
  logic [WIN_W-1:0] window_w;

  // Handshake: a window transfers on a posedge where out_valid && out_ready; while
  // out_valid is high and out_ready low, every out_* field is held unchanged.
  assign wr_ok = write && (32'(index_entry) < ENTRY_NUM) &&
                 (32'(index_y) < DIM) && (32'(index_x) < DIM);
  assign wr_addr = AW'((int'(index_entry) * DIM + int'(index_y)) * DIM + int'(index_x));

  always_ff @(posedge clk) begin
    if (wr_ok) mem_q[wr_addr] <= in_data;
  end

  // Cursor holds window indices; origins are derived so padding only shifts them.
  assign org_y    = int'(cy_q) * STRIDE - PAD;
  assign org_x    = int'(cx_q) * STRIDE - PAD;
  assign is_final = (cy_q == LAST_IDX) && (cx_q == LAST_IDX);

  always_comb begin
    window_w = '0;
    for (int e = 0; e < ENTRY_NUM; e++) begin
      for (int ky = 0; ky < KERNEL_DIM; ky++) begin
        for (int kx = 0; kx < KERNEL_DIM; kx++) begin
`ifdef ACT_WIN_ZERO_PAD_EN
          if ((org_y + ky >= 0) && (org_y + ky < DIM) && (org_x + kx >= 0) && (org_x + kx < DIM))
`endif
            window_w[((e * KERNEL_DIM + ky) * KERNEL_DIM + kx) * DATA_SIZE +: DATA_SIZE] =
              mem_q[AW'((e * DIM + org_y + ky) * DIM + org_x + kx)];
        end
      end
    end
  end

  always_comb begin
    state_d      = state_q;
    cy_d         = cy_q;
    cx_d         = cx_q;
    loaded_all_d = loaded_all_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
    out_valid_d  = out_valid_q;
    out_last_d   = out_last_q;
    out_data_d   = out_data_q;
    out_y_d      = out_y_q;
    out_x_d      = out_x_q;
    case (state_q)
      ST_IDLE: begin
        if (start) begin
          state_d      = ST_SCAN;
          busy_d       = 1'b1;
          cy_d         = '0;
          cx_d         = '0;
          loaded_all_d = 1'b0;
        end
      end
      ST_SCAN: begin
        if (out_valid_q && out_ready && out_last_q) begin
          state_d     = ST_DONE;
          out_valid_d = 1'b0;
          out_last_d  = 1'b0;
          busy_d      = 1'b0;
          done_d      = 1'b1;
        end else if ((!out_valid_q || out_ready) && !loaded_all_q) begin
          out_valid_d = 1'b1;
          out_data_d  = window_w;
          out_y_d     = org_y[15:0];
          out_x_d     = org_x[15:0];
          out_last_d  = is_final;
          if (is_final) begin
            loaded_all_d = 1'b1;
          end else if (cx_q == LAST_IDX) begin
            cx_d = '0;
            cy_d = cy_q + 16'd1;
          end else begin
            cx_d = cx_q + 16'd1;
          end
        end
      end
      ST_DONE: state_d = ST_IDLE;
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q      <= ST_IDLE;
      cy_q         <= '0;
      cx_q         <= '0;
      loaded_all_q <= 1'b0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
      out_valid_q  <= 1'b0;
      out_last_q   <= 1'b0;
      out_data_q   <= '0;
      out_y_q      <= '0;
      out_x_q      <= '0;
    end else begin
      state_q      <= state_d;
      cy_q         <= cy_d;
      cx_q         <= cx_d;
      loaded_all_q <= loaded_all_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
      out_valid_q  <= out_valid_d;
      out_last_q   <= out_last_d;
      out_data_q   <= out_data_d;
      out_y_q      <= out_y_d;
      out_x_q      <= out_x_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign out_valid = out_valid_q;
  assign out_last  = out_last_q;
  assign out_data  = out_data_q;
  assign out_y     = out_y_q;
  assign out_x     = out_x_q;

endmodule

// File: tb/tb_act_window_stream.sv
// Bench for act_window_stream: two instances (4x4 stride 1, 5x5 stride 2) checked
// against a window-list reference model built from the memory contents.
module tb_act_window_stream;

  localparam int E  = 2;
  localparam int K  = 3;
  localparam int W  = 16;
  localparam int OW = E * K * K * W;
  localparam int XW = 33 + OW;
`ifdef ACT_WIN_ZERO_PAD_EN
  localparam int PAD = (K - 1) / 2;
`else
  localparam int PAD = 0;
`endif

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          write;
  logic [15:0]   index_entry, index_y, index_x;
  logic [W-1:0]  in_data;
  logic          start_v     [2];
  logic          busy_v      [2];
  logic          done_v      [2];
  logic          out_valid_v [2];
  logic          out_ready_v [2];
  logic          out_last_v  [2];
  logic [OW-1:0] out_data_v  [2];
  logic [15:0]   out_y_v     [2];
  logic [15:0]   out_x_v     [2];

  act_window_stream #(.DEBUG(0), .ENTRY_NUM(E), .DIM(4), .DATA_SIZE(W), .KERNEL_DIM(K), .STRIDE(1)) u_a (
    .clk(clk), .rst_n(rst_n), .write(write), .index_entry(index_entry), .index_y(index_y),
    .index_x(index_x), .in_data(in_data), .start(start_v[0]), .busy(busy_v[0]), .done(done_v[0]),
    .out_valid(out_valid_v[0]), .out_ready(out_ready_v[0]), .out_data(out_data_v[0]),
    .out_y(out_y_v[0]), .out_x(out_x_v[0]), .out_last(out_last_v[0]));

  act_window_stream #(.DEBUG(0), .ENTRY_NUM(E), .DIM(5), .DATA_SIZE(W), .KERNEL_DIM(K), .STRIDE(2)) u_b (
    .clk(clk), .rst_n(rst_n), .write(write), .index_entry(index_entry), .index_y(index_y),
    .index_x(index_x), .in_data(in_data), .start(start_v[1]), .busy(busy_v[1]), .done(done_v[1]),
    .out_valid(out_valid_v[1]), .out_ready(out_ready_v[1]), .out_data(out_data_v[1]),
    .out_y(out_y_v[1]), .out_x(out_x_v[1]), .out_last(out_last_v[1]));

  logic [W-1:0]  mem_m [2][E][5][5];
  logic [XW-1:0] exp_q[$];
  int n_cmp = 0;
  int n_bad = 0;

  function automatic int dim_of(input int s);
    return (s == 0) ? 4 : 5;
  endfunction

  function automatic int str_of(input int s);
    return (s == 0) ? 1 : 2;
  endfunction

  task automatic check(input string tag, input logic [XW-1:0] obs, input logic [XW-1:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  function automatic logic [OW-1:0] win(input int s, input int oy, input int ox);
    logic [OW-1:0] r;
    r = '0;
    for (int e = 0; e < E; e++)
      for (int ky = 0; ky < K; ky++)
        for (int kx = 0; kx < K; kx++)
          if (oy + ky >= 0 && oy + ky < dim_of(s) && ox + kx >= 0 && ox + kx < dim_of(s))
            r[((e * K + ky) * K + kx) * W +: W] = mem_m[s][e][oy + ky][ox + kx];
    return r;
  endfunction

  task automatic build_exp(input int s);
    int n;
    int y;
    int x;
    exp_q.delete();
    n = (dim_of(s) + 2 * PAD - K) / str_of(s) + 1;
    for (int oy = 0; oy < n; oy++)
      for (int ox = 0; ox < n; ox++) begin
        y = oy * str_of(s) - PAD;
        x = ox * str_of(s) - PAD;
        exp_q.push_back({16'(y), 16'(x), (oy == n - 1) && (ox == n - 1), win(s, y, x)});
      end
  endtask

  task automatic wr(input int e, input int y, input int x, input logic [W-1:0] d);
    @(negedge clk);
    write = 1'b1;
    index_entry = 16'(e);
    index_y = 16'(y);
    index_x = 16'(x);
    in_data = d;
    @(negedge clk);
    write = 1'b0;
    for (int s = 0; s < 2; s++)
      if (e < E && y < dim_of(s) && x < dim_of(s)) mem_m[s][e][y][x] = d;
  endtask

  task automatic scan(input int s, input int stall_at, input int stall_len,
                      input int busy_start_at, input int abort_after, input bit rnd);
    int got = 0;
    int stalled = 0;
    int cyc = 0;
    bit fin = 1'b0;
    bit aborted = 1'b0;
    build_exp(s);
    @(negedge clk);
    start_v[s] = 1'b1;
    out_ready_v[s] = 1'b1;
    @(negedge clk);
    start_v[s] = 1'b0;
    check("busy_rise", XW'(busy_v[s]), XW'(1));
    check("valid_latency_1", XW'(out_valid_v[s]), XW'(0));
    @(negedge clk);
    check("valid_latency_2", XW'(out_valid_v[s]), XW'(1));
    while (!fin && cyc < 400) begin
      if (got == stall_at && stalled < stall_len && out_valid_v[s]) begin
        out_ready_v[s] = 1'b0;
        stalled++;
      end else begin
        out_ready_v[s] = rnd ? ($urandom_range(0, 3) != 0) : 1'b1;
      end
      start_v[s] = (cyc == busy_start_at);
      if (out_valid_v[s]) begin
        if (exp_q.size() == 0) begin
          check("extra_window", XW'(out_valid_v[s]), XW'(0));
          fin = 1'b1;
        end else begin
          check(out_ready_v[s] ? "window" : "held_window",
                {out_y_v[s], out_x_v[s], out_last_v[s], out_data_v[s]}, exp_q[0]);
          if (out_ready_v[s]) begin
            void'(exp_q.pop_front());
            got++;
          end
        end
      end
      cyc++;
      @(negedge clk);
      if (abort_after > 0 && got == abort_after) begin
        rst_n = 1'b0;
        #1;
        check("abort_ctrl", XW'({out_valid_v[s], busy_v[s], done_v[s]}), XW'(0));
        @(negedge clk);
        rst_n = 1'b1;
        exp_q.delete();
        fin = 1'b1;
        aborted = 1'b1;
      end else if (got > 0 && exp_q.size() == 0) begin
        fin = 1'b1;
      end
    end
    start_v[s] = 1'b0;
    check("scan_finished", XW'(fin), XW'(1));
    if (!aborted) begin
      check("windows_left", XW'(exp_q.size()), XW'(0));
      check("done_pulse", XW'({done_v[s], busy_v[s], out_valid_v[s]}), XW'(3'b100));
      @(negedge clk);
      check("done_fall", XW'({done_v[s], busy_v[s]}), XW'(0));
    end
  endtask

  initial begin
    rst_n = 1'b0;
    write = 1'b0;
    index_entry = '0;
    index_y = '0;
    index_x = '0;
    in_data = '0;
    for (int s = 0; s < 2; s++) begin
      start_v[s] = 1'b0;
      out_ready_v[s] = 1'b0;
    end
    repeat (3) @(negedge clk);
    for (int s = 0; s < 2; s++) begin
      check("reset_ctrl", XW'({busy_v[s], done_v[s], out_valid_v[s], out_last_v[s]}), XW'(0));
      check("reset_out", {out_y_v[s], out_x_v[s], out_last_v[s], out_data_v[s]}, XW'(0));
    end
    rst_n = 1'b1;

    for (int e = 0; e < E; e++)
      for (int y = 0; y < 5; y++)
        for (int x = 0; x < 5; x++) wr(e, y, x, '0);

    // Directed raster pattern, free-flowing consumer.
    for (int e = 0; e < E; e++)
      for (int y = 0; y < 4; y++)
        for (int x = 0; x < 4; x++) wr(e, y, x, 16'(e * 16 + y * 4 + x));
    scan(0, -1, 0, -1, 0, 1'b0);

    // Stall while the second window is presented.
    scan(0, 1, 3, -1, 0, 1'b0);

    // Stride-2 instance; columns/rows 4 are out of range for the 4x4 instance.
    for (int y = 0; y < 5; y++)
      for (int x = 0; x < 5; x++) wr(0, y, x, 16'(y * 5 + x));
    scan(1, -1, 0, -1, 0, 1'b0);

    // Out-of-range writes, then a valid one; start pulsed mid-scan.
    wr(0, 0, 4, 16'hdead);
    wr(0, 4, 0, 16'hbeef);
    wr(2, 0, 0, 16'hcafe);
    wr(1, 3, 3, 16'h1234);
    scan(0, -1, 0, 3, 0, 1'b0);
    scan(1, -1, 0, 2, 0, 1'b0);

    // Reset after the second handshake, then rescan from the origin.
    scan(0, -1, 0, -1, 2, 1'b0);
    scan(0, -1, 0, -1, 0, 1'b0);

    // Random contents, random consumer readiness.
    for (int i = 0; i < 40; i++)
      wr($urandom_range(0, 2), $urandom_range(0, 5), $urandom_range(0, 5), 16'($urandom));
    scan(0, 2, 2, -1, 0, 1'b1);
    scan(1, 1, 4, -1, 0, 1'b1);
    scan(0, -1, 0, -1, 0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
